// File: rtl/arbiter_rr_if.sv
// Request/grant bus between the requesting pipelines and the round-robin arbiter.
// master = pipeline/environment side, slave = arbiter side.
interface arbiter_rr_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
);
    logic [NUM_CH-1:0] in_valid;
    logic              in_ready;
    logic [CH_W-1:0]   out_choice;
    logic              out_valid;
    logic [NUM_CH-1:0] out_stall;

    modport master (
        output in_valid,
        output in_ready,
        input  out_choice,
        input  out_valid,
        input  out_stall
    );

    modport slave (
        input  in_valid,
        input  in_ready,
        output out_choice,
        output out_valid,
        output out_stall
    );
endinterface

// File: rtl/arbiter_rr.sv
// Round-robin arbiter: NUM_CH pipelines share one resource, zero-latency grant.
// Optional per-channel saturating grant counters when ARB_STATS_EN is defined.
`ifdef ARB_STATS_EN
module arb_stat_cnt #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [STAT_W-1:0] cnt
);
    logic [STAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule
`endif

module arbiter_rr #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH),
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    arbiter_rr_if.slave       arb,
    input  logic [CH_W-1:0]   in_stat_sel,
    input  logic              in_stat_clear,
    output logic [STAT_W-1:0] out_stat_count
);
    localparam logic [CH_W:0] NUM_CH_X = (CH_W+1)'(NUM_CH);

    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   choice;
    logic              grant_vld;
    logic [NUM_CH-1:0] grant_mask;

    // Modular add that stays below NUM_CH even when NUM_CH is not a power of two.
    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base,
                                                 input logic [CH_W-1:0] off);
        logic [CH_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= NUM_CH_X)
            sum = sum - NUM_CH_X;
        return sum[CH_W-1:0];
    endfunction

    // Walk from furthest to nearest so the channel closest to ptr wins.
    always_comb begin
        logic [CH_W-1:0] idx;
        choice = ptr_q;
        idx    = ptr_q;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = wrap_add(ptr_q, CH_W'(k));
            if (arb.in_valid[idx])
                choice = idx;
        end
    end

    always_comb begin
        grant_vld  = arb.in_ready && (arb.in_valid != '0);
        grant_mask = grant_vld ? (NUM_CH'(1) << choice) : '0;
        ptr_d      = grant_vld ? wrap_add(choice, CH_W'(1)) : ptr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    // Outputs are forced idle while reset is held, independent of the inputs.
    assign arb.out_choice = choice;
    assign arb.out_valid  = grant_vld && reset;
    assign arb.out_stall  = reset ? (arb.in_valid & ~grant_mask) : '0;

`ifdef ARB_STATS_EN
    logic [NUM_CH-1:0][STAT_W-1:0] cnt;
    logic [STAT_W-1:0]             stat_count_q, stat_count_d;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        arb_stat_cnt #(.STAT_W(STAT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (grant_vld && (choice == CH_W'(i))),
            .clr   (in_stat_clear),
            .cnt   (cnt[i])
        );
    end

    always_comb begin
        stat_count_d = '0;
        if ({1'b0, in_stat_sel} < NUM_CH_X)
            stat_count_d = cnt[in_stat_sel];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stat_count_q <= '0;
        else        stat_count_q <= stat_count_d;
    end

    assign out_stat_count = stat_count_q;
`else
    logic unused_stat;
    assign unused_stat    = ^{in_stat_sel, in_stat_clear};
    assign out_stat_count = '0;
`endif
endmodule

// File: tb/tb_arbiter_rr.sv
// Directed + random bench for arbiter_rr (4-channel and 3-channel instances)
// against a queue-free behavioural round-robin model.
module tb_arbiter_rr;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    arbiter_rr_if #(.NUM_CH(4)) a4 ();
    arbiter_rr_if #(.NUM_CH(3)) a3 ();

    logic [1:0]  sel4 = 2'd0, sel3 = 2'd0;
    logic        clr4 = 1'b0, clr3 = 1'b0;
    logic [3:0]  sc4;
    logic [15:0] sc3;

    arbiter_rr #(.NUM_CH(4), .STAT_W(4)) u4 (
        .clk(clk), .reset(reset), .arb(a4),
        .in_stat_sel(sel4), .in_stat_clear(clr4), .out_stat_count(sc4)
    );
    arbiter_rr #(.NUM_CH(3)) u3 (
        .clk(clk), .reset(reset), .arb(a3),
        .in_stat_sel(sel3), .in_stat_clear(clr3), .out_stat_count(sc3)
    );

    int checks = 0;
    int errors = 0;
    int m4_ptr = 0, m3_ptr = 0;
    int m4_cnt [4];
    int m4_stat = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First requester at or after ptr, wrapping; ptr itself when nobody requests.
    function automatic int pick(input int v, input int ptr, input int n);
        int idx;
        for (int k = 0; k < n; k++) begin
            idx = (ptr + k) % n;
            if (v[idx]) return idx;
        end
        return ptr;
    endfunction

    task automatic model_reset();
        m4_ptr = 0; m3_ptr = 0; m4_stat = 0;
        for (int i = 0; i < 4; i++) m4_cnt[i] = 0;
    endtask

    task automatic cyc(input logic [3:0] v4, input logic r4,
                       input logic [2:0] v3, input logic r3, input string tag);
        int e4, e3, s4, s3;
        bit g4, g3;
        @(negedge clk);
        a4.in_valid = v4; a4.in_ready = r4;
        a3.in_valid = v3; a3.in_ready = r3;
        #1;
        e4 = pick(int'(v4), m4_ptr, 4);
        e3 = pick(int'(v3), m3_ptr, 3);
        g4 = r4 && (v4 != 0);
        g3 = r3 && (v3 != 0);
        s4 = int'(v4); if (g4) s4 &= ~(1 << e4);
        s3 = int'(v3); if (g3) s3 &= ~(1 << e3);
        chk({tag, "/4choice"}, 32'(a4.out_choice), e4);
        chk({tag, "/4valid"},  32'(a4.out_valid),  32'(g4));
        chk({tag, "/4stall"},  32'(a4.out_stall),  s4);
        chk({tag, "/4stat"},   32'(sc4),           m4_stat);
        chk({tag, "/3choice"}, 32'(a3.out_choice), e3);
        chk({tag, "/3valid"},  32'(a3.out_valid),  32'(g3));
        chk({tag, "/3stall"},  32'(a3.out_stall),  s3);
        @(posedge clk);
        if (g4) m4_ptr = (e4 + 1) % 4;
        if (g3) m3_ptr = (e3 + 1) % 3;
`ifdef ARB_STATS_EN
        m4_stat = m4_cnt[sel4];
        if (clr4)
            for (int i = 0; i < 4; i++) m4_cnt[i] = 0;
        else if (g4 && m4_cnt[e4] < 15)
            m4_cnt[e4]++;
`else
        m4_stat = 0;
`endif
    endtask

    task automatic release_reset();
        @(negedge clk);
        a4.in_valid = '0; a4.in_ready = 1'b0;
        a3.in_valid = '0; a3.in_ready = 1'b0;
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        a4.in_valid = 4'hf; a4.in_ready = 1'b1;
        a3.in_valid = 3'h7; a3.in_ready = 1'b1;
        #12;
        chk("rst/4valid", 32'(a4.out_valid), 0);
        chk("rst/4stall", 32'(a4.out_stall), 0);
        chk("rst/4stat",  32'(sc4), 0);
        chk("rst/3valid", 32'(a3.out_valid), 0);
        chk("rst/3stall", 32'(a3.out_stall), 0);
        release_reset();

        // All-request rotation on both widths, then alternating requesters.
        for (int i = 0; i < 5; i++) cyc(4'b1111, 1'b1, 3'b111, 1'b1, "r033_r036");
        for (int i = 0; i < 4; i++) cyc(4'b1010, 1'b1, 3'b000, 1'b0, "r034");
        cyc(4'b0010, 1'b1, 3'b000, 1'b0, "ptr_to_2");
        for (int i = 0; i < 3; i++) cyc(4'b1111, 1'b0, 3'b101, 1'b0, "r035_hold");
        cyc(4'b1111, 1'b1, 3'b000, 1'b0, "r035_resume");
        chk("r035_ptr3", 32'(m4_ptr), 3);

        // Async reset mid-grant with ptr at 3.
        @(negedge clk);
        a4.in_valid = 4'hf; a4.in_ready = 1'b1;
        #1;
        chk("r037_pre_choice", 32'(a4.out_choice), 3);
        chk("r037_pre_valid",  32'(a4.out_valid),  1);
        #2 reset = 1'b0;
        #1;
        chk("r037_valid", 32'(a4.out_valid), 0);
        chk("r037_stall", 32'(a4.out_stall), 0);
        chk("r037_stat",  32'(sc4), 0);
        repeat (2) @(posedge clk);
        release_reset();
        cyc(4'b1111, 1'b1, 3'b111, 1'b1, "r037_after");

        // Single requester: granted every ready cycle, counter saturates.
        sel4 = 2'd0;
        for (int i = 0; i < 20; i++) cyc(4'b0001, 1'b1, 3'b010, 1'b1, "r038_inc");
`ifdef ARB_STATS_EN
        chk("r038_sat", 32'(sc4), 15);
`endif
        clr4 = 1'b1;
        cyc(4'b0001, 1'b1, 3'b000, 1'b0, "r038_clr");
        clr4 = 1'b0;
        cyc(4'b0000, 1'b0, 3'b000, 1'b0, "r038_post1");
        cyc(4'b0000, 1'b0, 3'b000, 1'b0, "r038_post2");
`ifdef ARB_STATS_EN
        chk("r038_zero", 32'(sc4), 0);
`endif

        // Random traffic, ready ~75%, occasional stat clear.
        for (int i = 0; i < 400; i++) begin
            sel4 = 2'($urandom_range(0, 3));
            sel3 = 2'($urandom_range(0, 3));
            clr4 = ($urandom_range(0, 19) == 0);
            clr3 = ($urandom_range(0, 19) == 0);
            cyc(4'($urandom), ($urandom_range(0, 3) != 0),
                3'($urandom), ($urandom_range(0, 3) != 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
